// File: rtl/touch_event_sched.sv
`default_nettype none
// ============================================================================
// touch_event_sched: debounces touch contacts into keypad pulses and EQ gains.
// Rev 1.0 -- optional TOUCH_AUTOREPEAT_EN adds held-button auto-repeat.
// ============================================================================
module touch_event_sched #(
    parameter logic [11:0] BTN_X0   = 12'd40,
    parameter logic [11:0] BTN_Y0   = 12'd300,
    parameter int          BTN_WSH  = 6,
    parameter logic [11:0] SLD_X0   = 12'd420,
    parameter logic [11:0] SLD_Y0   = 12'd60,
    parameter int          SLD_WSH  = 6,
    parameter int          SLD_HSH  = 5,
    parameter logic [15:0] DEB_CYC  = 16'd2000,
    parameter logic [15:0] REL_CYC  = 16'd2000,
    parameter logic [2:0]  GAIN_RST = 3'd3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        touch_act,
    input  logic        update,
    input  logic [11:0] touch_x,
    input  logic [11:0] touch_y,
    output logic [11:0] btn_pulse,
    output logic [2:0]  gain_one,
    output logic [2:0]  gain_two,
    output logic [2:0]  gain_three,
    output logic [2:0]  gain_four,
    output logic [2:0]  gain_five,
    output logic [2:0]  gain_six,
    output logic        gain_upd,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DEBOUNCE = 3'd1,
        CLASSIFY = 3'd2,
        BTN_HOLD = 3'd3,
        SLD_DRAG = 3'd4,
        RELEASE  = 3'd5
    } state_t;

    state_t      state;
    logic [15:0] cnt;
    logic [11:0] cx;
    logic [11:0] cy;
    logic [2:0]  band;
    logic [2:0]  gain [6];

`ifdef TOUCH_AUTOREPEAT_EN
    localparam logic [15:0] REP_DLY = 16'd25000;
    localparam logic [15:0] REP_CYC = 16'd10000;
    logic [15:0] rep_cnt;
    logic        rep_first;
    logic [3:0]  btn_held;
    logic [15:0] rep_lim;
    assign rep_lim = rep_first ? (REP_DLY - 16'd1) : (REP_CYC - 16'd1);
`endif

    // 13-bit differences: bit 12 set means the coordinate is left/above the region
    logic [12:0] bdx, bdy, sdx, sdy, ddy;
    logic [11:0] bcol, brow, sband, slvl, dlvl;
    logic        btn_hit, sld_hit;
    logic [3:0]  btn_idx;
    logic [2:0]  cls_gain, drag_gain;

    assign bdx = {1'b0, cx} - {1'b0, BTN_X0};
    assign bdy = {1'b0, cy} - {1'b0, BTN_Y0};
    assign sdx = {1'b0, cx} - {1'b0, SLD_X0};
    assign sdy = {1'b0, cy} - {1'b0, SLD_Y0};
    assign ddy = {1'b0, touch_y} - {1'b0, SLD_Y0};

    assign bcol  = bdx[11:0] >> BTN_WSH;
    assign brow  = bdy[11:0] >> BTN_WSH;
    assign sband = sdx[11:0] >> SLD_WSH;
    assign slvl  = sdy[11:0] >> SLD_HSH;
    assign dlvl  = ddy[11:0] >> SLD_HSH;

    assign btn_hit  = !bdx[12] && !bdy[12] && (bcol < 12'd4) && (brow < 12'd3);
    assign sld_hit  = !sdx[12] && !sdy[12] && (sband < 12'd6) && (slvl < 12'd8);
    assign btn_idx  = {brow[1:0], bcol[1:0]};
    assign cls_gain = 3'd7 - slvl[2:0];

    // Dragging clamps instead of rejecting: above the area is max gain, below is zero
    assign drag_gain = ddy[12]         ? 3'd7 :
                       (dlvl < 12'd8) ? (3'd7 - dlvl[2:0]) : 3'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            cx        <= '0;
            cy        <= '0;
            band      <= '0;
            btn_pulse <= '0;
            gain_upd  <= 1'b0;
            for (int i = 0; i < 6; i++) gain[i] <= GAIN_RST;
`ifdef TOUCH_AUTOREPEAT_EN
            rep_cnt   <= '0;
            rep_first <= 1'b1;
            btn_held  <= '0;
`endif
        end else begin
            btn_pulse <= '0;
            gain_upd  <= 1'b0;
            if (update) begin
                cx <= touch_x;
                cy <= touch_y;
            end
            case (state)
                IDLE: begin
                    if (touch_act && update) begin
                        state <= DEBOUNCE;
                        cnt   <= '0;
                    end
                end
                DEBOUNCE: begin
                    if (!touch_act)
                        state <= IDLE;
                    else if (cnt == DEB_CYC - 16'd1)
                        state <= CLASSIFY;
                    else
                        cnt <= cnt + 16'd1;
                end
                CLASSIFY: begin
                    if (btn_hit) begin
                        btn_pulse <= 12'd1 << btn_idx;
                        state     <= BTN_HOLD;
`ifdef TOUCH_AUTOREPEAT_EN
                        rep_cnt   <= '0;
                        rep_first <= 1'b1;
                        btn_held  <= btn_idx;
`endif
                    end else if (sld_hit) begin
                        band               <= sband[2:0];
                        gain[sband[2:0]]   <= cls_gain;
                        gain_upd           <= (gain[sband[2:0]] != cls_gain);
                        state              <= SLD_DRAG;
                    end else begin
                        state <= RELEASE;
                        cnt   <= '0;
                    end
                end
                BTN_HOLD: begin
                    if (!touch_act) begin
                        state <= RELEASE;
                        cnt   <= '0;
                    end
`ifdef TOUCH_AUTOREPEAT_EN
                    else if (rep_cnt == rep_lim) begin
                        btn_pulse <= 12'd1 << btn_held;
                        rep_cnt   <= '0;
                        rep_first <= 1'b0;
                    end else begin
                        rep_cnt <= rep_cnt + 16'd1;
                    end
`endif
                end
                SLD_DRAG: begin
                    if (update) begin
                        gain[band] <= drag_gain;
                        gain_upd   <= (gain[band] != drag_gain);
                    end
                    if (!touch_act) begin
                        state <= RELEASE;
                        cnt   <= '0;
                    end
                end
                RELEASE: begin
                    if (touch_act)
                        cnt <= '0;
                    else if (cnt == REL_CYC - 16'd1)
                        state <= IDLE;
                    else
                        cnt <= cnt + 16'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign gain_one   = gain[0];
    assign gain_two   = gain[1];
    assign gain_three = gain[2];
    assign gain_four  = gain[3];
    assign gain_five  = gain[4];
    assign gain_six   = gain[5];
    assign busy       = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_touch_event_sched.sv
`default_nettype none
// ============================================================================
// tb_touch_event_sched: scoreboard bench for touch_event_sched.
// Rev 1.0
// ============================================================================
module tb_touch_event_sched;

    logic        clk;
    logic        rst;
    logic        touch_act;
    logic        update;
    logic [11:0] touch_x;
    logic [11:0] touch_y;
    logic [11:0] btn_pulse;
    logic [2:0]  gain_one, gain_two, gain_three, gain_four, gain_five, gain_six;
    logic        gain_upd;
    logic        busy;

    touch_event_sched dut (
        .clk        (clk),
        .rst        (rst),
        .touch_act  (touch_act),
        .update     (update),
        .touch_x    (touch_x),
        .touch_y    (touch_y),
        .btn_pulse  (btn_pulse),
        .gain_one   (gain_one),
        .gain_two   (gain_two),
        .gain_three (gain_three),
        .gain_four  (gain_four),
        .gain_five  (gain_five),
        .gain_six   (gain_six),
        .gain_upd   (gain_upd),
        .busy       (busy)
    );

    localparam int DEB = 2000;
    localparam int REL = 2000;

    typedef struct {
        int          cyc;
        logic [11:0] val;
    } btn_exp_t;

    btn_exp_t    btn_q [$];
    logic [17:0] gain_q [$];
    btn_exp_t    mon_b;
    logic [17:0] mon_g;
    logic [2:0]  mg [6];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [17:0] act_gains();
        return {gain_six, gain_five, gain_four, gain_three, gain_two, gain_one};
    endfunction

    function automatic logic [17:0] model_gains();
        return {mg[5], mg[4], mg[3], mg[2], mg[1], mg[0]};
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents an event
    always @(negedge clk) begin
        if (!rst) begin
            if (btn_pulse != 12'd0) begin
                if (btn_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL btn_unexpected actual=%0h required=none (cycle %0d)", btn_pulse, cyc);
                end else begin
                    mon_b = btn_q.pop_front();
                    check("btn_value", {20'd0, btn_pulse}, {20'd0, mon_b.val});
                    check("btn_cycle", cyc, mon_b.cyc);
                    check("btn_onehot", $countones(btn_pulse), 1);
                end
            end
            if (gain_upd) begin
                if (gain_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL gain_unexpected actual=%0h required=none (cycle %0d)", act_gains(), cyc);
                end else begin
                    mon_g = gain_q.pop_front();
                    check("gain_value", {14'd0, act_gains()}, {14'd0, mon_g});
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [11:0] x, input logic [11:0] y, output int n);
        @(negedge clk);
        n         = cyc;
        touch_x   = x;
        touch_y   = y;
        touch_act = 1'b1;
        update    = 1'b1;
        @(negedge clk);
        update    = 1'b0;
    endtask

    task automatic sample(input logic [11:0] x, input logic [11:0] y);
        @(negedge clk);
        touch_x = x;
        touch_y = y;
        update  = 1'b1;
        @(negedge clk);
        update  = 1'b0;
    endtask

    task automatic let_go(input string name);
        @(negedge clk);
        touch_act = 1'b0;
        wait_cyc(REL + 10);
        check(name, {31'd0, busy}, 32'd0);
    endtask

    task automatic exp_btn(input int c, input logic [11:0] v);
        btn_exp_t e;
        e.cyc = c;
        e.val = v;
        btn_q.push_back(e);
    endtask

    task automatic exp_gain(input int band, input logic [2:0] g);
        mg[band] = g;
        gain_q.push_back(model_gains());
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        for (int i = 0; i < 6; i++) mg[i] = 3'd3;
        rst       = 1'b1;
        touch_act = 1'b0;
        update    = 1'b0;
        touch_x   = '0;
        touch_y   = '0;
        wait_cyc(3);
        check("rst_btn", {20'd0, btn_pulse}, 32'd0);
        check("rst_gain_upd", {31'd0, gain_upd}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_gains", {14'd0, act_gains()}, {14'd0, model_gains()});
        rst = 1'b0;
        wait_cyc(3);

        // Top-left button corner, then bottom-right button (row 2, col 3)
        press(12'd40, 12'd300, n);
        exp_btn(n + DEB + 2, 12'h001);
        wait_cyc(DEB + 100);
        let_go("btn0_idle");
        press(12'd295, 12'd491, n);
        exp_btn(n + DEB + 2, 12'h800);
        wait_cyc(DEB + 100);
        let_go("btn11_idle");

        // Bounce shorter than debounce window
        press(12'd40, 12'd300, n);
        wait_cyc(1499);
        touch_act = 1'b0;
        wait_cyc(5);
        check("bounce_idle", {31'd0, busy}, 32'd0);

        // Just outside the grid: col 4, and one pixel left of the grid
        press(12'd296, 12'd300, n);
        wait_cyc(DEB + 100);
        check("col4_release_busy", {31'd0, busy}, 32'd1);
        let_go("col4_idle");
        press(12'd39, 12'd300, n);
        wait_cyc(DEB + 100);
        let_go("x39_idle");

        // Release filter: short lift is absorbed, full lift re-arms
        press(12'd104, 12'd300, n);
        exp_btn(n + DEB + 2, 12'h002);
        wait_cyc(DEB + 100);
        @(negedge clk);
        touch_act = 1'b0;
        wait_cyc(1000);
        touch_act = 1'b1;
        wait_cyc(DEB + 100);
        let_go("relfilt_idle");
        press(12'd104, 12'd300, n);
        exp_btn(n + DEB + 2, 12'h002);
        wait_cyc(DEB + 100);
        let_go("relfilt2_idle");

        // Slider drag on band 2 (gain_three)
        exp_gain(2, 3'd7);
        press(12'd553, 12'd60, n);
        wait_cyc(DEB + 100);
        exp_gain(2, 3'd2);
        sample(12'd553, 12'd220);
        wait_cyc(5);
        exp_gain(2, 3'd0);
        sample(12'd553, 12'd400);
        wait_cyc(5);
        exp_gain(2, 3'd7);
        sample(12'd553, 12'd30);
        wait_cyc(5);
        exp_gain(2, 3'd2);
        sample(12'd553, 12'd221);
        wait_cyc(5);
        sample(12'd553, 12'd225);
        wait_cyc(5);
        exp_gain(2, 3'd7);
        sample(12'd100, 12'd60);
        wait_cyc(5);
        check("drag_busy", {31'd0, busy}, 32'd1);

        // Asynchronous reset mid-drag
        @(negedge clk);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) mg[i] = 3'd3;
        check("rst_async_gains", {14'd0, act_gains()}, {14'd0, model_gains()});
        check("rst_async_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        touch_act = 1'b0;
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(20);
        check("post_rst_gains", {14'd0, act_gains()}, {14'd0, model_gains()});
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        check("btn_q_empty", btn_q.size(), 32'd0);
        check("gain_q_empty", gain_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/touch_event_sched.md
Name: touch_event_sched

Overview:
- Sequences raw touch-controller results into discrete UI commands for the equalizer front panel.
- Consumes the coordinate/update stream from the I2C touch interface and debounces each contact.
- Classifies the contact into a keypad button (12 buttons, 4x3 grid) or an EQ slider band (6 bands, 8 gain levels).
- Issues one-cycle button pulses and registered gain values, replacing ad-hoc per-consumer touch decoding.

Parameters:
- BTN_X0, 12'd40, left edge of button grid (px)
- BTN_Y0, 12'd300, top edge of button grid (px)
- BTN_WSH, 6, log2 of button cell width and height (64 px cells)
- SLD_X0, 12'd420, left edge of slider area (px)
- SLD_Y0, 12'd60, top edge of slider area; top = gain 7
- SLD_WSH, 6, log2 of slider band width (64 px)
- SLD_HSH, 5, log2 of one gain-level height (32 px)
- DEB_CYC, 16'd2000, clocks touch_act must stay high before classification
- REL_CYC, 16'd2000, clocks touch_act must stay low to accept release
- GAIN_RST, 3'd3, reset/default gain of every band

Ports:
- clk  in  1  controller clock (I2C-domain clock)
- rst  in  1  asynchronous, active-high reset
- touch_act  in  1  contact present, active-high; the top level inverts the controller interrupt as needed
- update  in  1  one-cycle pulse: touch_x/touch_y hold a new sample
- touch_x  in  12  touch X coordinate
- touch_y  in  12  touch Y coordinate
- btn_pulse  out  12  one-hot, one-cycle button command; bit = row*4+col
- gain_one..gain_six  out  3 each  per-band gain, 0..7
- gain_upd  out  1  one-cycle pulse when any gain register changes
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: btn_pulse=0, gain_upd=0, all gains=GAIN_RST, busy=0, state=IDLE, counters=0, latched coordinates=0.
- Reset is asynchronous and takes effect mid-operation in any state; no pulse is emitted on reset exit.
- Every update pulse latches touch_x/touch_y into cx/cy, in all states.
- State machine:
  - IDLE: go to DEBOUNCE when touch_act=1 and update=1 in the same cycle; debounce counter cleared.
  - DEBOUNCE: counter increments while touch_act=1. touch_act=0 returns to IDLE with no event. Counter reaching DEB_CYC-1 moves to CLASSIFY.
  - CLASSIFY: one cycle, computed on cx/cy.
    - Button hit: col=(cx-BTN_X0)>>BTN_WSH, row=(cy-BTN_Y0)>>BTN_WSH; requires cx>=BTN_X0, cy>=BTN_Y0, col<4, row<3. Go to BTN_HOLD; the btn_pulse bit is asserted for exactly the next cycle.
    - Slider hit: band=(cx-SLD_X0)>>SLD_WSH, lvl=(cy-SLD_Y0)>>SLD_HSH; requires cx>=SLD_X0, cy>=SLD_Y0, band<6, lvl<8. Target gain = 7-lvl. Go to SLD_DRAG.
    - Otherwise: go to RELEASE.
    - Region edges are inclusive-left, exclusive-right (x0 <= x < x0+w). Subtraction is done in 13 bits so underflow is detected as out-of-region.
    - If button and slider regions overlap, the button wins.
  - BTN_HOLD: stays until touch_act=0, then RELEASE. Further updates produce no pulse.
  - SLD_DRAG: band is locked at entry. Each update re-evaluates lvl on the locked band. An in-range lvl writes gain=7-lvl. If cy is above the area the gain clamps to 7; if below, it clamps to 0. touch_act=0 goes to RELEASE.
  - RELEASE: release counter increments while touch_act=0; touch_act=1 clears it. Reaching REL_CYC-1 returns to IDLE.
- Gain write latency: the gain register changes 1 clock after CLASSIFY or after the update pulse. gain_upd pulses in the same cycle as the register change, and only if the new value differs from the old.
- An update coinciding with the CLASSIFY cycle is latched but ignored for classification.
- At most one btn_pulse bit is ever high; never two pulses per contact (without the optional feature).

Optional Feature:
- Macro: TOUCH_AUTOREPEAT_EN.
- Defined: in BTN_HOLD, after 0.5 s (REP_DLY = 16'd25000 clocks) of continuous hold, the same btn_pulse bit repeats every REP_CYC = 16'd10000 clocks until release.
- Undefined: exactly one pulse per press; the repeat counters are not synthesized.

Test Plan:
- Reset mid-drag: assert rst while in SLD_DRAG -> gains=3, busy=0 immediately (asynchronous), no gain_upd after release of rst.
- Button press: touch_act=1, update with (40,300) held 2000 clocks -> btn_pulse=12'h001 for exactly one clock, DEB_CYC+1 clocks after entry. Then (295,491) on a new press -> bit 11.
- Bounce: touch_act high for 1500 clocks then low -> no btn_pulse, no gain change, back to IDLE.
- Slider drag: touch at (420+64*2+5, 60) -> gain_thr=7 with gain_upd. Updates at y=60+32*5 -> gain_thr=2. y=400 -> gain_thr=0 (clamp). Other gains stay 3.
- Boundary: touch at (40+256, 300) (col=4) -> no pulse, RELEASE path. Touch at x=39 -> no pulse.
- Release filter: press button, drop touch_act for 1000 clocks, reassert -> no second pulse. Drop for 2000 clocks, then press -> second pulse.
